fd_pipe_reg: RTL and testbench

- Fetch-to-decode pipeline register sitting directly downstream of the fetch stage.
- Joins the fetch bundle (pcplus4, address-error flag) with the instruction word returned by the synchronous instruction memory, and presents a registered, valid-tagged bundle to decode.
- Holds a one-entry skid buffer so an instruction returned while decode is stalled is not lost.
- Discards stale memory responses after a flush, and generates the in_delay_slot flag consumed by fetch.

---
 rtl/fd_pipe_reg.sv | 171 +++++++++++++++++
 tb/tb_fd_pipe_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fd_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : fd_pipe_reg
// Brief    : Fetch-to-decode pipeline register with a one-entry skid buffer,
//            stale-response discard after flush and delay-slot tracking.
// Revision : 1.0
// ============================================================================
module fd_pipe_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_valid,
    input  logic [DW-1:0] f_pcplus4,
    input  logic          f_exception_instr,
    input  logic [DW-1:0] imem_rdata,
    input  logic          imem_data_ok,
    input  logic          stall,
    input  logic          flush,
    input  logic          d_is_branch,
    output logic          f_stall_req,
    output logic          in_delay_slot,
    output logic          d_valid,
    output logic [DW-1:0] d_instr,
    output logic [DW-1:0] d_pcplus4,
    output logic          d_exception_instr,
    output logic          d_in_delay_slot
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SKID = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic          d_valid_q, d_valid_d;
    logic [DW-1:0] d_instr_q, d_instr_d;
    logic [DW-1:0] d_pc_q, d_pc_d;
    logic          d_exc_q, d_exc_d;
    logic          d_ds_q, d_ds_d;

    logic [DW-1:0] skid_instr_q, skid_instr_d;
    logic [DW-1:0] skid_pc_q, skid_pc_d;
    logic          skid_ds_q, skid_ds_d;

    logic          pending_ds_q, pending_ds_d;

    logic          w_f_ready;
    logic [DW-1:0] w_instr;
    logic          w_in_ds;
    logic          w_outstanding;
    logic          w_stall_req;

    // An address-error PC never reaches memory, so it is ready at once as a nop.
    assign w_f_ready     = f_valid & (f_exception_instr | imem_data_ok);
    assign w_instr       = f_exception_instr ? '0 : imem_rdata;
    assign w_in_ds       = (d_valid_q & d_is_branch) | pending_ds_q;
    assign w_outstanding = f_valid & ~f_exception_instr & ~imem_data_ok;

    always_comb begin
        w_stall_req = 1'b1;
        if (state_q == RUN) begin
            w_stall_req = (f_valid & ~w_f_ready) | stall;
        end
    end

    assign f_stall_req   = reset ? 1'b0 : w_stall_req;
    assign in_delay_slot = reset ? 1'b0 : w_in_ds;

    always_comb begin
        state_d      = state_q;
        d_valid_d    = d_valid_q;
        d_instr_d    = d_instr_q;
        d_pc_d       = d_pc_q;
        d_exc_d      = d_exc_q;
        d_ds_d       = d_ds_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_ds_d    = skid_ds_q;
        pending_ds_d = pending_ds_q;

        if (flush) begin
            d_valid_d    = 1'b0;
            pending_ds_d = 1'b0;
            // A response still owed from before an earlier flush keeps us in DROP.
            if (((state_q == DROP) & ~imem_data_ok) | w_outstanding) begin
                state_d = DROP;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        d_valid_d = w_f_ready;
                        d_instr_d = w_instr;
                        d_pc_d    = f_pcplus4;
                        d_exc_d   = f_exception_instr;
                        d_ds_d    = w_in_ds;
                        if (w_f_ready) begin
                            pending_ds_d = 1'b0;
                        end else if (d_valid_q & d_is_branch) begin
                            pending_ds_d = 1'b1;
                        end
                    end else if (w_f_ready & ~f_exception_instr) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = f_pcplus4;
                        skid_ds_d    = w_in_ds;
                        state_d      = SKID;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        d_valid_d    = 1'b1;
                        d_instr_d    = skid_instr_q;
                        d_pc_d       = skid_pc_q;
                        d_exc_d      = 1'b0;
                        d_ds_d       = skid_ds_q;
                        pending_ds_d = 1'b0;
                        state_d      = RUN;
                    end
                end
                DROP: begin
                    d_valid_d = 1'b0;
                    if (imem_data_ok) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            d_valid_q    <= 1'b0;
            d_instr_q    <= '0;
            d_pc_q       <= '0;
            d_exc_q      <= 1'b0;
            d_ds_q       <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_ds_q    <= 1'b0;
            pending_ds_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            d_valid_q    <= d_valid_d;
            d_instr_q    <= d_instr_d;
            d_pc_q       <= d_pc_d;
            d_exc_q      <= d_exc_d;
            d_ds_q       <= d_ds_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_ds_q    <= skid_ds_d;
            pending_ds_q <= pending_ds_d;
        end
    end

    assign d_valid           = d_valid_q;
    assign d_instr           = d_instr_q;
    assign d_pcplus4         = d_pc_q;
    assign d_exception_instr = d_exc_q;
    assign d_in_delay_slot   = d_ds_q;

endmodule
`default_nettype wire

// File: tb/tb_fd_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_fd_pipe_reg
// Brief    : Directed and randomized bench for fd_pipe_reg with a behavioural
//            reference model (held-bundle queue plus discard flag).
// Revision : 1.0
// ============================================================================
module tb_fd_pipe_reg;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_valid;
    logic [DW-1:0] f_pcplus4;
    logic          f_exception_instr;
    logic [DW-1:0] imem_rdata;
    logic          imem_data_ok;
    logic          stall;
    logic          flush;
    logic          d_is_branch;
    logic          f_stall_req;
    logic          in_delay_slot;
    logic          d_valid;
    logic [DW-1:0] d_instr;
    logic [DW-1:0] d_pcplus4;
    logic          d_exception_instr;
    logic          d_in_delay_slot;

    fd_pipe_reg #(.DW(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .f_valid           (f_valid),
        .f_pcplus4         (f_pcplus4),
        .f_exception_instr (f_exception_instr),
        .imem_rdata        (imem_rdata),
        .imem_data_ok      (imem_data_ok),
        .stall             (stall),
        .flush             (flush),
        .d_is_branch       (d_is_branch),
        .f_stall_req       (f_stall_req),
        .in_delay_slot     (in_delay_slot),
        .d_valid           (d_valid),
        .d_instr           (d_instr),
        .d_pcplus4         (d_pcplus4),
        .d_exception_instr (d_exception_instr),
        .d_in_delay_slot   (d_in_delay_slot)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
        logic          ds;
    } bundle_t;

    // Reference model: what decode sees, bundles waiting for decode, and
    // whether one stale memory response must still be thrown away.
    bit            m_valid;
    logic [DW-1:0] m_instr;
    logic [DW-1:0] m_pc;
    bit            m_exc;
    bit            m_ds;
    bit            m_known;
    bit            m_pend;
    bit            m_drop;
    bundle_t       held[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit fv, input logic [DW-1:0] pc, input bit exc,
                        input logic [DW-1:0] rdata, input bit dok, input bit stl,
                        input bit fl, input bit br);
        bit            rdy;
        bit            ids;
        bit            exp_req;
        logic [DW-1:0] ins;
        bundle_t       b;
        reset = rst; f_valid = fv; f_pcplus4 = pc; f_exception_instr = exc;
        imem_rdata = rdata; imem_data_ok = dok; stall = stl; flush = fl; d_is_branch = br;
        #1;
        rdy     = fv && (exc || dok);
        ins     = exc ? '0 : rdata;
        ids     = (m_valid && br) || m_pend;
        exp_req = rst ? 1'b0 : ((m_drop || held.size() != 0) ? 1'b1 : ((fv && !rdy) || stl));
        check("f_stall_req", {31'd0, f_stall_req}, {31'd0, exp_req});
        check("in_delay_slot", {31'd0, in_delay_slot}, {31'd0, rst ? 1'b0 : ids});

        if (rst) begin
            m_valid = 0; m_instr = '0; m_pc = '0; m_exc = 0; m_ds = 0;
            m_known = 1; m_pend = 0; m_drop = 0; held.delete();
        end else if (fl) begin
            m_drop  = (m_drop && !dok) || (fv && !exc && !dok);
            held.delete();
            m_valid = 0; m_pend = 0; m_known = 0;
        end else if (m_drop) begin
            m_valid = 0; m_known = 0;
            if (dok) m_drop = 0;
        end else if (held.size() != 0) begin
            if (!stl) begin
                b = held.pop_front();
                m_valid = 1; m_instr = b.instr; m_pc = b.pc; m_exc = 0; m_ds = b.ds;
                m_known = 1; m_pend = 0;
            end
        end else if (!stl) begin
            if (rdy) begin
                m_valid = 1; m_instr = ins; m_pc = pc; m_exc = exc; m_ds = ids;
                m_known = 1; m_pend = 0;
            end else begin
                if (m_valid && br) m_pend = 1;
                m_valid = 0; m_known = 0;
            end
        end else if (rdy && !exc) begin
            held.push_back('{instr: rdata, pc: pc, ds: ids});
        end

        @(posedge clk);
        #1;
        check("d_valid", {31'd0, d_valid}, {31'd0, m_valid});
        if (m_known) begin
            check("d_instr", d_instr, m_instr);
            check("d_pcplus4", d_pcplus4, m_pc);
            check("d_exception_instr", {31'd0, d_exception_instr}, {31'd0, m_exc});
            check("d_in_delay_slot", {31'd0, d_in_delay_slot}, {31'd0, m_ds});
        end
    endtask

    initial begin
        logic [DW-1:0] pc;
        bit            exc;
        reset = 1; f_valid = 0; f_pcplus4 = '0; f_exception_instr = 0;
        imem_rdata = '0; imem_data_ok = 0; stall = 0; flush = 0; d_is_branch = 0;
        m_known = 1;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Straight-line fetch
        step(0, 1, 32'hBFC00004, 0, 32'h11111111, 1, 0, 0, 0);
        check("line_pc0", d_pcplus4, 32'hBFC00004);
        step(0, 1, 32'hBFC00008, 0, 32'h22222222, 1, 0, 0, 0);
        check("line_pc1", d_pcplus4, 32'hBFC00008);

        // Stall with data: captured while stalled, delivered once afterwards
        step(0, 1, 32'hBFC0000C, 0, 32'h24020001, 1, 1, 0, 0);
        step(0, 1, 32'hBFC0000C, 0, 32'h0, 0, 1, 0, 0);
        step(0, 1, 32'hBFC0000C, 0, 32'h0, 0, 1, 0, 0);
        check("skid_hold_pc", d_pcplus4, 32'hBFC00008);
        step(0, 1, 32'hBFC0000C, 0, 32'h0, 0, 0, 0, 0);
        check("skid_out", d_instr, 32'h24020001);
        step(0, 1, 32'hBFC00010, 0, 32'h33333333, 1, 0, 0, 0);
        check("skid_next", d_instr, 32'h33333333);

        // Slow memory
        step(0, 1, 32'hBFC00014, 0, 32'h0, 0, 0, 0, 0);
        step(0, 1, 32'hBFC00014, 0, 32'h0, 0, 0, 0, 0);
        step(0, 1, 32'hBFC00014, 0, 32'h44444444, 1, 0, 0, 0);
        check("slow_instr", d_instr, 32'h44444444);

        // Flush with an outstanding request; late response is discarded
        step(0, 1, 32'hBFC00018, 0, 32'h0, 0, 0, 1, 0);
        step(0, 1, 32'hBFC00100, 0, 32'h0, 0, 0, 0, 0);
        step(0, 1, 32'hBFC00100, 0, 32'hDEADBEEF, 1, 0, 0, 0);
        check("drop_valid", {31'd0, d_valid}, 32'd0);
        step(0, 1, 32'hBFC00100, 0, 32'h55555555, 1, 0, 0, 0);
        check("after_drop", d_instr, 32'h55555555);

        // Delay slot across a bubble
        step(0, 1, 32'hBFC00104, 0, 32'h10000003, 1, 0, 0, 0);
        step(0, 1, 32'hBFC00108, 0, 32'h0, 0, 0, 0, 1);
        step(0, 1, 32'hBFC00108, 0, 32'h66666666, 1, 0, 0, 0);
        check("ds_set", {31'd0, d_in_delay_slot}, 32'd1);
        step(0, 1, 32'hBFC0010C, 0, 32'h77777777, 1, 0, 0, 0);
        check("ds_clear", {31'd0, d_in_delay_slot}, 32'd0);

        // Address error needs no memory response
        step(0, 1, 32'hBFC00111, 1, 32'h88888888, 0, 0, 0, 0);
        check("exc_instr", d_instr, 32'd0);
        check("exc_flag", {31'd0, d_exception_instr}, 32'd1);

        // Reset in the middle of SKID
        step(0, 1, 32'hBFC00200, 0, 32'h99999999, 1, 1, 0, 0);
        step(1, 1, 32'hBFC00200, 0, 32'h0, 0, 1, 0, 0);
        check("rst_valid", {31'd0, d_valid}, 32'd0);
        check("rst_instr", d_instr, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            exc = ($urandom_range(0, 9) == 0);
            pc  = ($urandom & 32'hFFFFFFFC) | (exc ? 32'd2 : 32'd0);
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 85), pc, exc, $urandom,
                 ($urandom_range(0, 99) < 65),
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 30));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
